ysyx_22051013_cache_tag_array: RTL and testbench
================================================

# ysyx_22051013_cache_tag_array

Parametrised N-way set-associative tag array for the pipelined CPU's I/D caches: per-set tag, valid and dirty storage, registered hit compare, victim selection via a per-set round-robin pointer, and a hardware invalidate-all sweep. Sits between the cache controller FSM and the data RAMs; the controller issues lookups and tag writes, and waits on `busy` after reset or `fence.i`.

## Interface
- `SET_BITS`, 6, index width; sets = 2^SET_BITS
- `TAG_W`, 23, tag width
- `WAY_BITS`, 1, log2 of way count; WAYS = 2^WAY_BITS (1..3 legal)
- `clk` in 1 clock, all logic on rising edge
- `rst` in 1 synchronous active-high reset
- `inv_req` in 1 pulse: start invalidate-all sweep
- `busy` out 1 sweep in progress; lookups and writes ignored
- `lk_valid` in 1 lookup request
- `lk_idx` in SET_BITS lookup set
- `lk_tag` in TAG_W lookup tag
- `hit` out 1 registered: any valid way matched
- `hit_way` out WAYS one-hot matching way
- `vic_way` out WAY_BITS victim way (round-robin pointer of set)
- `vic_tag` out TAG_W tag stored in victim way
- `vic_valid` out 1 victim valid bit
- `vic_dirty` out 1 victim dirty bit
- `wr_en` in 1 tag write
- `wr_idx` in SET_BITS write set
- `wr_way` in WAY_BITS write way
- `wr_tag` in TAG_W written tag
- `wr_valid` in 1 written valid bit
- `wr_dirty` in 1 written dirty bit

## Operation
- Storage: per way, 2^SET_BITS entries of {dirty, valid, tag}; per set, WAY_BITS-bit round-robin pointer.
- Lookup: accepted when `lk_valid && !busy`. Read is synchronous; compare and victim fields registered together.
- `hit_way[w]` = valid[w] && tag[w]==lk_tag; `hit` = OR of `hit_way`. Multiple matches are a controller bug; outputs then are OR'd, no detection.
- Output registers hold their value when no lookup is accepted.
- Write: accepted when `wr_en && !busy`; writes all three fields of (wr_idx, wr_way). When `wr_valid` and `wr_way` equals the set's pointer, the pointer increments mod WAYS.
- Read/write same set same cycle: lookup returns pre-write contents (read-before-write); pointer returned is pre-increment.
- Sweep FSM: states IDLE, SWEEP. IDLE->SWEEP on `rst` or `inv_req`. In SWEEP, counter `sw_idx` clears valid, dirty and pointer of set `sw_idx` in every way each cycle; SWEEP->IDLE after set 2^SET_BITS-1. Tags are not cleared.
- `inv_req` while in SWEEP: ignored (no restart). `rst` mid-sweep: restart at set 0.
- Dirty data is not written back by this block; controller must drain dirty lines before `inv_req`.

## Timing
- `rst` high: `busy`=1 next cycle; `hit`, `hit_way`, `vic_*` = 0; `sw_idx`=0.
- Sweep duration: exactly 2^SET_BITS cycles after the cycle `rst` falls or `inv_req` is sampled; `busy` falls on the following edge (64 cycles at default).
- Lookup latency: 1 cycle (request edge N, outputs valid after edge N+1).
- Write visible to a lookup issued the cycle after the write.
- `inv_req` and `wr_en` same cycle in IDLE: write is performed, then sweep clears it.

## Configuration
- `YSYX_22051013_CACHE_DIRTY_EN` defined: dirty bit stored, written, swept, and reported on `vic_dirty` (D-cache, write-back).
- Undefined: no dirty storage; `wr_dirty` ignored; `vic_dirty` tied 0 (I-cache).

## Structure
- Shared package/header: SET_BITS, TAG_W, WAY_BITS defaults, entry field offsets (tag, valid, dirty), sweep FSM state encodings.
- One sub-module: `ysyx_22051013_cache_tag_way`, single-way sync-read RAM with write enable and per-entry clear port for the sweep; instantiated WAYS times via generate.

## Test plan
- Reset: pulse `rst` 1 cycle -> `busy`=1 for 64 cycles, all outputs 0; lookup at idx 5 afterwards -> `hit`=0, `vic_valid`=0, `vic_way`=0.
- Fill/hit: write idx 0x12 way 1 tag 0x1ABCDE valid=1; lookup idx 0x12 tag 0x1ABCDE -> `hit`=1, `hit_way`=2'b10 next cycle; tag 0x1ABCDF -> `hit`=0.
- Round-robin: idx 3, pointer 0; fill way 0 -> `vic_way`=1; fill way 1 -> `vic_way`=0; fill way 1 again -> pointer stays 0.
- Dirty/victim (macro on): write idx 7 way 0 tag 0x55 valid=1 dirty=1; lookup idx 7 -> `vic_tag`=0x55, `vic_valid`=1, `vic_dirty`=1; macro off -> `vic_dirty`=0.
- Read-before-write: lookup and write same set same cycle -> lookup reports old tag; repeat lookup next cycle -> new tag.
- Invalidate: fill several sets, `inv_req` -> 64 busy cycles, lookups/writes during sweep ignored, all later lookups miss; `rst` at sweep cycle 30 -> full 64-cycle restart.

Source files
------------

// File: rtl/ysyx_22051013_cache_tag_array_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22051013_cache_tag_array_pkg
//
// Shared definitions for the cache tag array slice:
//   - default geometry (SET_BITS, TAG_W, WAY_BITS)
//   - entry layout inside a way RAM read word: {dirty, valid, tag}
//   - invalidate-sweep FSM state encoding
// ---------------------------------------------------------------------------
package ysyx_22051013_cache_tag_array_pkg;

  localparam int SET_BITS_DEF = 6;
  localparam int TAG_W_DEF    = 23;
  localparam int WAY_BITS_DEF = 1;

  // Entry layout: tag occupies the low bits, valid sits just above it,
  // dirty is the top bit.
  localparam int ENTRY_TAG_LSB = 0;

  function automatic int entry_valid_pos(input int tag_w);
    return tag_w;
  endfunction

  function automatic int entry_dirty_pos(input int tag_w);
    return tag_w + 1;
  endfunction

  function automatic int entry_width(input int tag_w);
    return tag_w + 2;
  endfunction

  typedef enum logic {
    SW_IDLE  = 1'b0,
    SW_SWEEP = 1'b1
  } sweep_state_e;

endpackage

// File: rtl/ysyx_22051013_cache_tag_way.sv
// ---------------------------------------------------------------------------
// ysyx_22051013_cache_tag_way
//
// One way of the tag array: 2^SET_BITS entries of {dirty, valid, tag}.
// Synchronous read (read-before-write on a same-cycle collision), one write
// port, and a clear port that drops valid/dirty of one entry per cycle for
// the invalidate sweep. Tags are never cleared.
//
// Build option: YSYX_22051013_CACHE_DIRTY_EN stores the dirty bit; without it
// the dirty field always reads 0 and wr_dirty is ignored.
//
// Ports:
//   clk               clock
//   rd_en/rd_idx      read request; rd_entry holds its value when rd_en is low
//   rd_entry          registered {dirty, valid, tag}
//   wr_en/wr_idx      write request
//   wr_tag/wr_valid/wr_dirty   written fields
//   clr_en/clr_idx    clear valid and dirty of one entry (wins over write)
// ---------------------------------------------------------------------------
module ysyx_22051013_cache_tag_way
  import ysyx_22051013_cache_tag_array_pkg::*;
#(
  parameter  int SET_BITS = SET_BITS_DEF,
  parameter  int TAG_W    = TAG_W_DEF,
  localparam int ENTRY_W  = entry_width(TAG_W)
) (
  input  logic                clk,
  input  logic                rd_en,
  input  logic [SET_BITS-1:0] rd_idx,
  output logic [ENTRY_W-1:0]  rd_entry,
  input  logic                wr_en,
  input  logic [SET_BITS-1:0] wr_idx,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic                wr_valid,
  input  logic                wr_dirty,
  input  logic                clr_en,
  input  logic [SET_BITS-1:0] clr_idx
);

  localparam int SETS      = 1 << SET_BITS;
  localparam int VALID_POS = entry_valid_pos(TAG_W);
  localparam int DIRTY_POS = entry_dirty_pos(TAG_W);

  // NOTE: storage has no reset; valid/dirty are brought to a known state by
  // the sweep that every reset starts, and stale tags are harmless once invalid.
  logic [TAG_W-1:0] tag_mem [SETS];
  logic [SETS-1:0]  valid_q;
  logic             rd_dirty;
  logic [ENTRY_W-1:0] rd_word;

  always_ff @(posedge clk) begin
    if (wr_en) tag_mem[wr_idx] <= wr_tag;
  end

  always_ff @(posedge clk) begin
    if (clr_en)     valid_q[clr_idx] <= 1'b0;
    else if (wr_en) valid_q[wr_idx]  <= wr_valid;
  end

`ifdef YSYX_22051013_CACHE_DIRTY_EN
  logic [SETS-1:0] dirty_q;

  always_ff @(posedge clk) begin
    if (clr_en)     dirty_q[clr_idx] <= 1'b0;
    else if (wr_en) dirty_q[wr_idx]  <= wr_dirty;
  end

  assign rd_dirty = dirty_q[rd_idx];
`else
  logic unused_wr_dirty;
  assign unused_wr_dirty = wr_dirty;
  assign rd_dirty        = 1'b0;
`endif

  always_comb begin
    rd_word                            = '0;
    rd_word[ENTRY_TAG_LSB +: TAG_W]    = tag_mem[rd_idx];
    rd_word[VALID_POS]                 = valid_q[rd_idx];
    rd_word[DIRTY_POS]                 = rd_dirty;
  end

  // Registered read; the register only loads on rd_en so the lookup result
  // holds between accepted lookups.
  always_ff @(posedge clk) begin
    if (rd_en) rd_entry <= rd_word;
  end

endmodule

// File: rtl/ysyx_22051013_cache_tag_array.sv
// ---------------------------------------------------------------------------
// ysyx_22051013_cache_tag_array
//
// N-way set-associative tag array: registered hit compare, round-robin victim
// selection per set, and an invalidate-all sweep started by rst or inv_req.
//
// Build option: YSYX_22051013_CACHE_DIRTY_EN enables dirty storage (D-cache);
// when undefined vic_dirty is always 0 (I-cache).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset (starts a sweep)
//   inv_req             start invalidate-all sweep (ignored while busy)
//   busy                sweep in progress; lookups and writes are ignored
//   lk_valid/lk_idx/lk_tag      lookup request
//   hit, hit_way        registered compare result (one-hot per way)
//   vic_way/vic_tag/vic_valid/vic_dirty   victim = round-robin way of the set
//   wr_en/wr_idx/wr_way/wr_tag/wr_valid/wr_dirty   tag entry write
// ---------------------------------------------------------------------------
module ysyx_22051013_cache_tag_array
  import ysyx_22051013_cache_tag_array_pkg::*;
#(
  parameter  int SET_BITS = SET_BITS_DEF,
  parameter  int TAG_W    = TAG_W_DEF,
  parameter  int WAY_BITS = WAY_BITS_DEF,
  localparam int WAYS     = 1 << WAY_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inv_req,
  output logic                busy,
  input  logic                lk_valid,
  input  logic [SET_BITS-1:0] lk_idx,
  input  logic [TAG_W-1:0]    lk_tag,
  output logic                hit,
  output logic [WAYS-1:0]     hit_way,
  output logic [WAY_BITS-1:0] vic_way,
  output logic [TAG_W-1:0]    vic_tag,
  output logic                vic_valid,
  output logic                vic_dirty,
  input  logic                wr_en,
  input  logic [SET_BITS-1:0] wr_idx,
  input  logic [WAY_BITS-1:0] wr_way,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic                wr_valid,
  input  logic                wr_dirty
);

  localparam int SETS      = 1 << SET_BITS;
  localparam int ENTRY_W   = entry_width(TAG_W);
  localparam int VALID_POS = entry_valid_pos(TAG_W);
  localparam int DIRTY_POS = entry_dirty_pos(TAG_W);

  sweep_state_e        state_q, state_d;
  logic [SET_BITS-1:0] sw_idx_q, sw_idx_d;
  logic                sweep_clr;
  logic                lk_acc;
  logic                wr_acc;

  logic [WAY_BITS-1:0] ptr_q [SETS];
  logic                out_vld_q;
  logic [TAG_W-1:0]    lk_tag_q;
  logic [WAY_BITS-1:0] vic_way_q;
  logic [ENTRY_W-1:0]  rd_entry [WAYS];
  logic [ENTRY_W-1:0]  vic_entry;

  assign busy   = (state_q == SW_SWEEP);
  assign lk_acc = lk_valid && !busy;
  assign wr_acc = wr_en && !busy;

  // ---------------- sweep FSM ----------------
  // rst (re)starts the sweep at set 0, including mid-sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SW_SWEEP;
      sw_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      sw_idx_q <= sw_idx_d;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    sw_idx_d  = sw_idx_q;
    sweep_clr = 1'b0;
    unique case (state_q)
      SW_IDLE: begin
        if (inv_req) begin
          state_d  = SW_SWEEP;
          sw_idx_d = '0;
        end
      end
      SW_SWEEP: begin
        sweep_clr = 1'b1;
        sw_idx_d  = sw_idx_q + SET_BITS'(1);
        if (sw_idx_q == '1) state_d = SW_IDLE;
      end
    endcase
  end

  // ---------------- ways ----------------
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic way_wr;
    assign way_wr = wr_acc && (wr_way == WAY_BITS'(w));

    ysyx_22051013_cache_tag_way #(
      .SET_BITS (SET_BITS),
      .TAG_W    (TAG_W)
    ) u_way (
      .clk      (clk),
      .rd_en    (lk_acc),
      .rd_idx   (lk_idx),
      .rd_entry (rd_entry[w]),
      .wr_en    (way_wr),
      .wr_idx   (wr_idx),
      .wr_tag   (wr_tag),
      .wr_valid (wr_valid),
      .wr_dirty (wr_dirty),
      .clr_en   (sweep_clr),
      .clr_idx  (sw_idx_q)
    );

    assign hit_way[w] = out_vld_q && rd_entry[w][VALID_POS]
                        && (rd_entry[w][ENTRY_TAG_LSB +: TAG_W] == lk_tag_q);
  end

  // ---------------- round-robin pointers ----------------
  // The pointer only advances when the way it names is filled, so refilling
  // a non-victim way leaves the victim choice alone. Sweep and write never
  // coincide because writes are ignored while busy.
  always_ff @(posedge clk) begin
    if (sweep_clr) begin
      ptr_q[sw_idx_q] <= '0;
    end else if (wr_acc && wr_valid && (wr_way == ptr_q[wr_idx])) begin
      ptr_q[wr_idx] <= ptr_q[wr_idx] + WAY_BITS'(1);
    end
  end

  // ---------------- lookup registers ----------------
  // out_vld_q gates every result to zero from reset until the first accepted
  // lookup; the RAM read registers themselves carry no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      vic_way_q <= '0;
    end else if (lk_acc) begin
      out_vld_q <= 1'b1;
      vic_way_q <= ptr_q[lk_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (lk_acc) lk_tag_q <= lk_tag;
  end

  assign vic_entry = rd_entry[vic_way_q];

  // Multiple matching ways are a controller error; they are simply OR'd.
  assign hit       = |hit_way;
  assign vic_way   = vic_way_q;
  assign vic_tag   = out_vld_q ? vic_entry[ENTRY_TAG_LSB +: TAG_W] : '0;
  assign vic_valid = out_vld_q && vic_entry[VALID_POS];
  assign vic_dirty = out_vld_q && vic_entry[DIRTY_POS];

endmodule

// File: tb/tb_ysyx_22051013_cache_tag_array.sv
`timescale 1ns/1ps
module tb_ysyx_22051013_cache_tag_array;

  localparam int SET_BITS = 6;
  localparam int TAG_W    = 23;
  localparam int WAY_BITS = 1;
  localparam int WAYS     = 1 << WAY_BITS;
  localparam int SETS     = 1 << SET_BITS;

`ifdef YSYX_22051013_CACHE_DIRTY_EN
  localparam bit DIRTY_EN = 1'b1;
`else
  localparam bit DIRTY_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst, inv_req, busy;
  logic                lk_valid;
  logic [SET_BITS-1:0] lk_idx;
  logic [TAG_W-1:0]    lk_tag;
  logic                hit;
  logic [WAYS-1:0]     hit_way;
  logic [WAY_BITS-1:0] vic_way;
  logic [TAG_W-1:0]    vic_tag;
  logic                vic_valid, vic_dirty;
  logic                wr_en;
  logic [SET_BITS-1:0] wr_idx;
  logic [WAY_BITS-1:0] wr_way;
  logic [TAG_W-1:0]    wr_tag;
  logic                wr_valid, wr_dirty;

  always #5 clk = ~clk;

  ysyx_22051013_cache_tag_array #(
    .SET_BITS (SET_BITS),
    .TAG_W    (TAG_W),
    .WAY_BITS (WAY_BITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inv_req   (inv_req),
    .busy      (busy),
    .lk_valid  (lk_valid),
    .lk_idx    (lk_idx),
    .lk_tag    (lk_tag),
    .hit       (hit),
    .hit_way   (hit_way),
    .vic_way   (vic_way),
    .vic_tag   (vic_tag),
    .vic_valid (vic_valid),
    .vic_dirty (vic_dirty),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_way    (wr_way),
    .wr_tag    (wr_tag),
    .wr_valid  (wr_valid),
    .wr_dirty  (wr_dirty)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  // Since nothing is observable while busy, a sweep is modelled as clearing
  // everything at once plus a countdown of busy cycles.
  logic [TAG_W-1:0] m_tag   [WAYS][SETS];
  bit               m_known [WAYS][SETS];
  bit               m_valid [WAYS][SETS];
  bit               m_dirty [WAYS][SETS];
  int               m_ptr   [SETS];
  int               m_busy_left = 0;

  logic             exp_hit;
  logic [WAYS-1:0]  exp_hit_way;
  logic [WAY_BITS-1:0] exp_vic_way;
  logic [TAG_W-1:0] exp_vic_tag;
  logic             exp_vic_valid, exp_vic_dirty;
  bit               exp_tag_known;

  task automatic model_clear();
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < SETS; s++) begin
        m_valid[w][s] = 1'b0;
        m_dirty[w][s] = 1'b0;
      end
    for (int s = 0; s < SETS; s++) m_ptr[s] = 0;
  endtask

  task automatic model_write();
    int w, s;
    w = int'(wr_way);
    s = int'(wr_idx);
    m_tag[w][s]   = wr_tag;
    m_known[w][s] = 1'b1;
    m_valid[w][s] = wr_valid;
    m_dirty[w][s] = wr_dirty;
    if (wr_valid && w == m_ptr[s]) m_ptr[s] = (m_ptr[s] + 1) % WAYS;
  endtask

  // One clock edge; the model consumes the inputs the DUT sampled at it.
  task automatic tick();
    bit pre_busy;
    int s, v;
    @(posedge clk);
    pre_busy = (m_busy_left != 0);
    if (rst) begin
      if (!pre_busy && wr_en) model_write();
      model_clear();
      m_busy_left   = SETS;
      exp_hit       = 1'b0;
      exp_hit_way   = '0;
      exp_vic_way   = '0;
      exp_vic_tag   = '0;
      exp_vic_valid = 1'b0;
      exp_vic_dirty = 1'b0;
      exp_tag_known = 1'b1;
    end else if (pre_busy) begin
      m_busy_left--;
    end else begin
      if (lk_valid) begin
        s = int'(lk_idx);
        exp_hit_way = '0;
        for (int w = 0; w < WAYS; w++)
          if (m_valid[w][s] && m_tag[w][s] == lk_tag) exp_hit_way[w] = 1'b1;
        exp_hit       = (exp_hit_way != '0);
        v             = m_ptr[s];
        exp_vic_way   = WAY_BITS'(v);
        exp_vic_tag   = m_tag[v][s];
        exp_tag_known = m_known[v][s];
        exp_vic_valid = m_valid[v][s];
        exp_vic_dirty = DIRTY_EN && m_dirty[v][s];
      end
      if (wr_en) model_write();
      if (inv_req) begin
        model_clear();
        m_busy_left = SETS;
      end
    end
    #1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic do_write(input int idx, input int way, input logic [TAG_W-1:0] tag,
                          input bit v, input bit d);
    wr_en = 1'b1; wr_idx = SET_BITS'(idx); wr_way = WAY_BITS'(way);
    wr_tag = tag; wr_valid = v; wr_dirty = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_lookup(input int idx, input logic [TAG_W-1:0] tag);
    lk_valid = 1'b1; lk_idx = SET_BITS'(idx); lk_tag = tag;
    tick();
    lk_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int n;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL reset_busy: got %b want 1", busy);
    end
    checks++;
    if ({hit, hit_way, vic_way, vic_valid, vic_dirty} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: hit=%b hit_way=%b vic_way=%0d vic_valid=%b vic_dirty=%b want all 0",
               hit, hit_way, vic_way, vic_valid, vic_dirty);
    end
    checks++;
    if (vic_tag !== '0) begin
      errors++; $display("FAIL reset_vic_tag: got %h want 0", vic_tag);
    end
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      tick(); n++;
    end
    checks++;
    if (n != 64) begin
      errors++; $display("FAIL reset_busy_cycles: got %0d want 64", n);
    end
    do_lookup(5, TAG_W'(32'h123));
    checks++;
    if (hit !== 1'b0 || vic_valid !== 1'b0 || vic_way !== '0) begin
      errors++;
      $display("FAIL reset_lookup: hit=%b vic_valid=%b vic_way=%0d want 0 0 0", hit, vic_valid, vic_way);
    end
  endtask

  task automatic test_fill_hit();
    do_write(8'h12, 1, TAG_W'(32'h1ABCDE), 1'b1, 1'b0);
    do_lookup(8'h12, TAG_W'(32'h1ABCDE));
    checks++;
    if (hit !== 1'b1 || hit_way !== 2'b10) begin
      errors++; $display("FAIL fill_hit: hit=%b hit_way=%b want 1 10", hit, hit_way);
    end
    do_lookup(8'h12, TAG_W'(32'h1ABCDF));
    checks++;
    if (hit !== 1'b0 || hit_way !== 2'b00) begin
      errors++; $display("FAIL fill_miss: hit=%b hit_way=%b want 0 00", hit, hit_way);
    end
  endtask

  task automatic test_round_robin();
    do_lookup(3, TAG_W'(32'h0));
    checks++;
    if (vic_way !== 1'b0) begin
      errors++; $display("FAIL rr_initial: vic_way=%0d want 0", vic_way);
    end
    do_write(3, 0, TAG_W'(32'h300), 1'b1, 1'b0);
    do_lookup(3, TAG_W'(32'h300));
    checks++;
    if (vic_way !== 1'b1 || hit_way !== 2'b01) begin
      errors++; $display("FAIL rr_fill0: vic_way=%0d hit_way=%b want 1 01", vic_way, hit_way);
    end
    do_write(3, 1, TAG_W'(32'h301), 1'b1, 1'b0);
    do_lookup(3, TAG_W'(32'h301));
    checks++;
    if (vic_way !== 1'b0 || hit_way !== 2'b10) begin
      errors++; $display("FAIL rr_fill1: vic_way=%0d hit_way=%b want 0 10", vic_way, hit_way);
    end
    do_write(3, 1, TAG_W'(32'h302), 1'b1, 1'b0);
    do_lookup(3, TAG_W'(32'h302));
    checks++;
    if (vic_way !== 1'b0 || hit_way !== 2'b10) begin
      errors++; $display("FAIL rr_refill1: vic_way=%0d hit_way=%b want 0 10", vic_way, hit_way);
    end
  endtask

  task automatic test_dirty_victim();
    do_write(7, 0, TAG_W'(32'h55), 1'b1, 1'b1);   // pointer 0 -> 1
    do_write(7, 1, TAG_W'(32'h66), 1'b1, 1'b0);   // pointer 1 -> 0
    do_lookup(7, TAG_W'(32'h55));
    checks++;
    if (vic_way !== 1'b0 || vic_tag !== TAG_W'(32'h55) || vic_valid !== 1'b1) begin
      errors++;
      $display("FAIL dirty_victim_fields: vic_way=%0d vic_tag=%h vic_valid=%b want 0 55 1",
               vic_way, vic_tag, vic_valid);
    end
    checks++;
    if (vic_dirty !== DIRTY_EN) begin
      errors++; $display("FAIL dirty_victim_dirty: got %b want %b", vic_dirty, DIRTY_EN);
    end
    checks++;
    if (hit !== 1'b1 || hit_way !== 2'b01) begin
      errors++; $display("FAIL dirty_victim_hit: hit=%b hit_way=%b want 1 01", hit, hit_way);
    end
  endtask

  task automatic test_read_before_write();
    do_write(8'h20, 0, TAG_W'(32'h2AAAA), 1'b1, 1'b0);  // pointer 0 -> 1
    do_write(8'h20, 1, TAG_W'(32'h2CCCC), 1'b1, 1'b0);  // pointer 1 -> 0
    // Same cycle: look up the old tag while way 0 (the pointer) is overwritten.
    lk_valid = 1'b1; lk_idx = SET_BITS'(8'h20); lk_tag = TAG_W'(32'h2AAAA);
    wr_en = 1'b1; wr_idx = SET_BITS'(8'h20); wr_way = 1'b0;
    wr_tag = TAG_W'(32'h2BBBB); wr_valid = 1'b1; wr_dirty = 1'b0;
    tick();
    wr_en = 1'b0;
    checks++;
    if (hit !== 1'b1 || hit_way !== 2'b01 || vic_way !== 1'b0 || vic_tag !== TAG_W'(32'h2AAAA)) begin
      errors++;
      $display("FAIL rbw_collision: hit=%b hit_way=%b vic_way=%0d vic_tag=%h want 1 01 0 2aaaa",
               hit, hit_way, vic_way, vic_tag);
    end
    tick();  // repeat the same lookup of the old tag
    lk_valid = 1'b0;
    checks++;
    if (hit !== 1'b0 || vic_way !== 1'b1 || vic_tag !== TAG_W'(32'h2CCCC)) begin
      errors++;
      $display("FAIL rbw_old_gone: hit=%b vic_way=%0d vic_tag=%h want 0 1 2cccc", hit, vic_way, vic_tag);
    end
    do_lookup(8'h20, TAG_W'(32'h2BBBB));
    checks++;
    if (hit !== 1'b1 || hit_way !== 2'b01) begin
      errors++; $display("FAIL rbw_new_tag: hit=%b hit_way=%b want 1 01", hit, hit_way);
    end
  endtask

  task automatic test_invalidate();
    int n;
    int idxs [5];
    int tags [5];
    idxs = '{32'h12, 3, 7, 32'h30, 32'h31};
    tags = '{32'h1ABCDE, 32'h302, 32'h55, 32'h777, 32'h999};
    do_lookup(7, TAG_W'(32'h55));
    // inv_req together with a write: the write lands, then the sweep clears it.
    inv_req = 1'b1;
    wr_en = 1'b1; wr_idx = SET_BITS'(8'h30); wr_way = 1'b0;
    wr_tag = TAG_W'(32'h777); wr_valid = 1'b1; wr_dirty = 1'b1;
    tick();
    inv_req = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL inv_busy: got %b want 1", busy);
    end
    // Requests during the sweep must be ignored.
    lk_valid = 1'b1; lk_idx = SET_BITS'(8'h12); lk_tag = TAG_W'(32'h1ABCDF);
    wr_en = 1'b1; wr_idx = SET_BITS'(8'h31); wr_way = 1'b1; wr_tag = TAG_W'(32'h999); wr_valid = 1'b1;
    inv_req = 1'b1;   // also ignored: no restart
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      tick(); n++;
    end
    lk_valid = 1'b0; wr_en = 1'b0; inv_req = 1'b0;
    checks++;
    if (n != 64) begin
      errors++; $display("FAIL inv_busy_cycles: got %0d want 64", n);
    end
    checks++;
    if (hit !== 1'b1 || hit_way !== 2'b01) begin
      errors++; $display("FAIL inv_hold: hit=%b hit_way=%b want 1 01", hit, hit_way);
    end
    for (int i = 0; i < 5; i++) begin
      do_lookup(idxs[i], TAG_W'(tags[i]));
      checks++;
      if (hit !== 1'b0 || vic_valid !== 1'b0 || vic_way !== 1'b0 || vic_dirty !== 1'b0) begin
        errors++;
        $display("FAIL inv_miss idx=%0h: hit=%b vic_valid=%b vic_way=%0d vic_dirty=%b want 0 0 0 0",
                 idxs[i], hit, vic_valid, vic_way, vic_dirty);
      end
    end
    // rst in the middle of a sweep restarts it from set 0.
    do_write(4, 0, TAG_W'(32'h444), 1'b1, 1'b0);
    do_lookup(4, TAG_W'(32'h444));
    inv_req = 1'b1;
    tick();
    inv_req = 1'b0;
    repeat (29) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b1 || hit !== 1'b0 || hit_way !== 2'b00) begin
      errors++; $display("FAIL rst_mid_sweep_outputs: busy=%b hit=%b hit_way=%b want 1 0 00", busy, hit, hit_way);
    end
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      tick(); n++;
    end
    checks++;
    if (n != 64) begin
      errors++; $display("FAIL rst_mid_sweep_cycles: got %0d want 64", n);
    end
  endtask

  task automatic test_random();
    logic [TAG_W-1:0] pool [4];
    pool = '{TAG_W'(32'h1ABCDE), TAG_W'(32'h0055), TAG_W'(32'h7FFFFF), TAG_W'(32'h12345)};
    for (int i = 0; i < 800; i++) begin
      rst      = ($urandom_range(399) == 0);
      inv_req  = ($urandom_range(99) == 0);
      lk_valid = ($urandom_range(1) == 1);
      lk_idx   = SET_BITS'($urandom_range(3));
      lk_tag   = pool[$urandom_range(3)];
      wr_en    = ($urandom_range(2) == 0);
      wr_idx   = SET_BITS'($urandom_range(3));
      wr_way   = WAY_BITS'($urandom_range(WAYS - 1));
      wr_tag   = pool[$urandom_range(3)];
      wr_valid = ($urandom_range(3) != 0);
      wr_dirty = ($urandom_range(1) == 1);
      tick();
      checks++;
      if ({busy, hit, hit_way, vic_way, vic_valid, vic_dirty} !==
          {(m_busy_left != 0), exp_hit, exp_hit_way, exp_vic_way, exp_vic_valid, exp_vic_dirty}) begin
        errors++;
        $display("FAIL random[%0d]: busy=%b hit=%b hit_way=%b vic_way=%0d vic_valid=%b vic_dirty=%b want %b %b %b %0d %b %b",
                 i, busy, hit, hit_way, vic_way, vic_valid, vic_dirty, (m_busy_left != 0),
                 exp_hit, exp_hit_way, exp_vic_way, exp_vic_valid, exp_vic_dirty);
      end
      if (exp_tag_known) begin
        checks++;
        if (vic_tag !== exp_vic_tag) begin
          errors++; $display("FAIL random_vic_tag[%0d]: got %h want %h", i, vic_tag, exp_vic_tag);
        end
      end
    end
    rst = 1'b0; inv_req = 1'b0; lk_valid = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; inv_req = 1'b0;
    lk_valid = 1'b0; lk_idx = '0; lk_tag = '0;
    wr_en = 1'b0; wr_idx = '0; wr_way = '0; wr_tag = '0; wr_valid = 1'b0; wr_dirty = 1'b0;
    exp_hit = 1'b0; exp_hit_way = '0; exp_vic_way = '0; exp_vic_tag = '0;
    exp_vic_valid = 1'b0; exp_vic_dirty = 1'b0; exp_tag_known = 1'b0;
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < SETS; s++) begin
        m_tag[w][s] = '0; m_known[w][s] = 1'b0;
      end
    model_clear();

    test_reset();
    test_fill_hit();
    test_round_robin();
    test_dirty_victim();
    test_read_before_write();
    test_invalidate();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
